// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage. Holds the architectural PC, issues one request at a
// time to a variable-latency instruction memory and loads the IF/ID register.
// A one-entry buffer keeps a word that returns while the pipeline is stalled.
// A redirect from ID that lands while a fetch is outstanding arms a kill flag,
// which discards the stale word when it eventually returns.
module fetch_stage #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] NOP_INSTR  = 16'h0000,
   parameter logic [3:0]  HLT_OPCODE = 4'b1111
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_valid,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc,
   output logic [15:0] if_id_plus2pc,
   output logic        if_id_valid,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic        buf_valid_q, buf_valid_d;
   logic [15:0] buf_data_q, buf_data_d;
   logic [15:0] if_id_instr_q, if_id_instr_d;
   logic [15:0] if_id_pc_q, if_id_pc_d;
   logic [15:0] if_id_plus2pc_q, if_id_plus2pc_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic        halted_q, halted_d;

   logic [15:0] plus2_s;
   logic        issue_s;
   logic        deliver_s;
   logic        bubble_s;
   logic [15:0] deliver_data_s;

   // PC+2 wraps naturally modulo 2^16
   assign plus2_s = pc_q + 16'd2;

   // A fetch launches only from ISSUE with an empty buffer, no stall and no
   // redirect; gating with rst_n keeps the strobe low while reset is held.
   assign issue_s   = (state_q == ST_ISSUE) && !buf_valid_q && !stall && !redirect;
   assign imem_req  = issue_s && rst_n;
   assign imem_addr = pc_q;

   assign if_id_instr   = if_id_instr_q;
   assign if_id_pc      = if_id_pc_q;
   assign if_id_plus2pc = if_id_plus2pc_q;
   assign if_id_valid   = if_id_valid_q;
   assign halted        = halted_q;

   // Next-state, PC, buffer and IF/ID update logic
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      kill_d          = kill_q;
      buf_valid_d     = buf_valid_q;
      buf_data_d      = buf_data_q;
      if_id_instr_d   = if_id_instr_q;
      if_id_pc_d      = if_id_pc_q;
      if_id_plus2pc_d = if_id_plus2pc_q;
      if_id_valid_d   = if_id_valid_q;
      halted_d        = halted_q;
      deliver_s       = 1'b0;
      bubble_s        = 1'b0;
      deliver_data_s  = buf_data_q;

      if (redirect) begin
         // Redirect beats stall: flush IF/ID and the buffer, leave HALT
         pc_d          = redirect_pc;
         if_id_instr_d = NOP_INSTR;
         if_id_valid_d = 1'b0;
         buf_valid_d   = 1'b0;
         halted_d      = 1'b0;
         if ((state_q == ST_WAIT) && !imem_valid) begin
            // The old word is still in flight; drop it when it arrives
            kill_d  = 1'b1;
            state_d = ST_WAIT;
         end else begin
            kill_d  = 1'b0;
            state_d = ST_ISSUE;
         end
      end else begin
         case (state_q)
            ST_ISSUE: begin
               if (stall) begin
                  state_d = ST_ISSUE;
               end else if (buf_valid_q) begin
                  deliver_s      = 1'b1;
                  deliver_data_s = buf_data_q;
                  buf_valid_d    = 1'b0;
               end else begin
                  state_d  = ST_WAIT;
                  bubble_s = 1'b1;
               end
            end
            ST_WAIT: begin
               if (imem_valid) begin
                  if (kill_q) begin
                     kill_d   = 1'b0;
                     state_d  = ST_ISSUE;
                     bubble_s = !stall;
                  end else if (stall) begin
                     buf_valid_d = 1'b1;
                     buf_data_d  = imem_rdata;
                     state_d     = ST_ISSUE;
                  end else begin
                     deliver_s      = 1'b1;
                     deliver_data_s = imem_rdata;
                  end
               end else begin
                  bubble_s = !stall;
               end
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: begin
               state_d = ST_ISSUE;
            end
         endcase

         if (deliver_s) begin
            if_id_instr_d   = deliver_data_s;
            if_id_pc_d      = pc_q;
            if_id_plus2pc_d = plus2_s;
            if_id_valid_d   = 1'b1;
            if (deliver_data_s[15:12] == HLT_OPCODE) begin
               // PC stays on the HLT so a later redirect is the only way out
               state_d  = ST_HALT;
               halted_d = 1'b1;
            end else begin
               pc_d    = plus2_s;
               state_d = ST_ISSUE;
            end
         end else if (bubble_s) begin
            // Nothing delivered this cycle: insert a bubble, keep PC fields
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
         end else begin
            if_id_valid_d = if_id_valid_q;
         end
      end
   end

   // State, PC, buffer and IF/ID registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_ISSUE;
         pc_q            <= RESET_PC;
         kill_q          <= 1'b0;
         buf_valid_q     <= 1'b0;
         buf_data_q      <= 16'h0000;
         if_id_instr_q   <= NOP_INSTR;
         if_id_pc_q      <= 16'h0000;
         if_id_plus2pc_q <= 16'h0000;
         if_id_valid_q   <= 1'b0;
         halted_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         kill_q          <= kill_d;
         buf_valid_q     <= buf_valid_d;
         buf_data_q      <= buf_data_d;
         if_id_instr_q   <= if_id_instr_d;
         if_id_pc_q      <= if_id_pc_d;
         if_id_plus2pc_q <= if_id_plus2pc_d;
         if_id_valid_q   <= if_id_valid_d;
         halted_q        <= halted_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Scoreboard bench: a memory responder records the expected IF/ID contents for
// every request from an architectural PC model; a separate monitor pops and
// compares whenever IF/ID presents a new valid instruction.
module tb_fetch_stage;

   localparam logic [15:0] NOP = 16'h0000;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
      logic [15:0] plus2;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata = 16'h0000;
   logic        imem_valid = 1'b0;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc;
   logic [15:0] if_id_plus2pc;
   logic        if_id_valid;
   logic        halted;

   exp_t        exp_q[$];
   logic [15:0] mem [0:255];
   int          checks = 0;
   int          errors = 0;
   int          deliveries = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   logic [15:0] model_pc = 16'h0000;
   logic        hlt_pend = 1'b0;
   logic        model_halted = 1'b0;

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC  (16'h0000),
      .NOP_INSTR (16'h0000),
      .HLT_OPCODE(4'hF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_valid   (imem_valid),
      .if_id_instr  (if_id_instr),
      .if_id_pc     (if_id_pc),
      .if_id_plus2pc(if_id_plus2pc),
      .if_id_valid  (if_id_valid),
      .halted       (halted)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_req(input logic [15:0] a);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(imem_req === 1'b1 && imem_addr === a) && n < 200);
      chk("wait_req_found", {15'd0, (imem_req === 1'b1 && imem_addr === a)}, 16'd1);
   endtask

   task automatic wait_any_req();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (imem_req !== 1'b1 && n < 200);
      chk("wait_any_req_found", {15'd0, imem_req}, 16'd1);
   endtask

   task automatic pulse_redirect(input logic [15:0] tgt);
      @(posedge clk);
      #1;
      redirect    = 1'b1;
      redirect_pc = tgt;
      @(posedge clk);
      #1;
      redirect = 1'b0;
   endtask

   // Memory responder and architectural PC model
   initial begin : responder
      int          cnt;
      logic        pend;
      logic [15:0] raddr;
      exp_t        e;
      pend  = 1'b0;
      cnt   = 0;
      raddr = 16'h0000;
      forever begin
         @(negedge clk);
         imem_valid = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt <= 0) begin
               imem_valid = 1'b1;
               imem_rdata = mem[raddr[8:1]];
               pend       = 1'b0;
            end
         end
         if (!rst_n) begin
            model_pc = 16'h0000;
            hlt_pend = 1'b0;
         end else if (redirect) begin
            chk("req_during_redirect", {15'd0, imem_req}, 16'd0);
            model_pc = redirect_pc;
            hlt_pend = 1'b0;
         end else if (imem_req) begin
            chk("imem_addr", imem_addr, model_pc);
            chk("req_rule_pend_hlt_stall", {13'd0, pend, hlt_pend, stall}, 16'd0);
            e.instr = mem[model_pc[8:1]];
            e.pc    = model_pc;
            e.plus2 = model_pc + 16'd2;
            exp_q.push_back(e);
            if (e.instr[15:12] == 4'hF) hlt_pend = 1'b1;
            else model_pc = model_pc + 16'd2;
            pend  = 1'b1;
            raddr = imem_addr;
            cnt   = $urandom_range(lat_min, lat_max);
         end
      end
   end

   // Monitor: compares IF/ID and halted after every active edge
   initial begin : monitor
      exp_t        e;
      logic        prev_stall;
      logic        prev_redir;
      logic [15:0] s_instr, s_pc, s_p2;
      logic        s_valid;
      int          idle;
      prev_stall = 1'b0;
      prev_redir = 1'b0;
      s_instr = 16'h0; s_pc = 16'h0; s_p2 = 16'h0; s_valid = 1'b0;
      idle = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            model_halted = 1'b0;
            idle = 0;
         end else begin
            if (prev_redir) begin
               chk("redirect_flush_valid", {15'd0, if_id_valid}, 16'd0);
               chk("redirect_flush_instr", if_id_instr, NOP);
               idle = 0;
            end else if (model_halted || prev_stall) begin
               chk("hold_instr", if_id_instr, s_instr);
               chk("hold_pc", if_id_pc, s_pc);
               chk("hold_plus2", if_id_plus2pc, s_p2);
               chk("hold_valid", {15'd0, if_id_valid}, {15'd0, s_valid});
               idle = 0;
            end else if (if_id_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_delivery", if_id_instr, NOP);
                  chk("unexpected_delivery_valid", {15'd0, if_id_valid}, 16'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("deliver_instr", if_id_instr, e.instr);
                  chk("deliver_pc", if_id_pc, e.pc);
                  chk("deliver_plus2", if_id_plus2pc, e.plus2);
                  deliveries++;
                  if (e.instr[15:12] == 4'hF) model_halted = 1'b1;
               end
               idle = 0;
            end else begin
               chk("bubble_instr", if_id_instr, NOP);
               idle++;
               if (idle > 30) begin
                  chk("fetch_watchdog", 16'(idle), 16'd0);
                  idle = 0;
               end
            end
            chk("halted", {15'd0, halted}, {15'd0, model_halted});
            if (redirect) begin
               exp_q.delete();
               model_halted = 1'b0;
            end
         end
         s_instr    = if_id_instr;
         s_pc       = if_id_pc;
         s_p2       = if_id_plus2pc;
         s_valid    = if_id_valid;
         prev_stall = stall;
         prev_redir = redirect;
      end
   end

   // Directed scenarios followed by a randomized run
   initial begin : stim
      int n;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 16'($urandom);
      end
      for (int i = 0; i < 8; i++) begin
         if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'h7;
      end
      for (int i = 16; i < 40; i++) begin
         if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'h7;
      end
      if (mem[255][15:12] == 4'hF) mem[255][15:12] = 4'h7;
      mem[0] = 16'h1234;
      mem[1] = 16'h2345;
      mem[8] = 16'hF000;

      #1;
      chk("reset_instr", if_id_instr, NOP);
      chk("reset_pc", if_id_pc, 16'h0000);
      chk("reset_plus2", if_id_plus2pc, 16'h0000);
      chk("reset_valid", {15'd0, if_id_valid}, 16'd0);
      chk("reset_req", {15'd0, imem_req}, 16'd0);
      chk("reset_halted", {15'd0, halted}, 16'd0);
      chk("reset_addr", imem_addr, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1-cycle memory for 0x0000/0x0002, then 3-cycle latency
      wait_req(16'h0000);
      wait_req(16'h0002);
      wait_req(16'h0004);
      lat_min = 3;
      lat_max = 3;
      // redirect while the 0x0008 fetch is outstanding
      wait_req(16'h0008);
      lat_min = 1;
      lat_max = 1;
      pulse_redirect(16'h0040);
      wait_req(16'h0040);
      // stall held two cycles while the 0x0042 word returns
      wait_req(16'h0042);
      @(posedge clk);
      #1;
      stall = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      stall = 1'b0;

      // HLT at 0x0010, then resume at 0x0020
      pulse_redirect(16'h0010);
      n = 0;
      while (halted !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("hlt_halted", {15'd0, halted}, 16'd1);
      chk("hlt_instr", if_id_instr, 16'hF000);
      chk("hlt_pc", if_id_pc, 16'h0010);
      repeat (5) @(posedge clk);
      pulse_redirect(16'h0020);
      wait_req(16'h0020);

      // randomized traffic
      lat_min = 1;
      lat_max = 4;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk);
         #1;
         stall    = ($urandom_range(0, 4) == 0);
         redirect = ($urandom_range(0, 11) == 0);
         if (redirect) redirect_pc = {15'($urandom_range(0, 32767)), 1'b0};
      end
      @(posedge clk);
      #1;
      stall    = 1'b0;
      redirect = 1'b0;

      // PC wrap at 0xFFFE
      pulse_redirect(16'hFFFE);
      wait_req(16'hFFFE);
      wait_req(16'h0000);

      // asynchronous reset in the middle of a 3-cycle fetch
      lat_min = 3;
      lat_max = 3;
      wait_any_req();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      stall = 1'b1;
      #1;
      chk("midreset_instr", if_id_instr, NOP);
      chk("midreset_pc", if_id_pc, 16'h0000);
      chk("midreset_plus2", if_id_plus2pc, 16'h0000);
      chk("midreset_valid", {15'd0, if_id_valid}, 16'd0);
      chk("midreset_req", {15'd0, imem_req}, 16'd0);
      chk("midreset_halted", {15'd0, halted}, 16'd0);
      chk("midreset_addr", imem_addr, 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      stall = 1'b0;
      wait_req(16'h0000);
      repeat (40) @(posedge clk);
      #1;

      chk("pending_at_end_le1", {15'd0, (exp_q.size() > 1)}, 16'd0);
      chk("enough_deliveries", {15'd0, (deliveries > 20)}, 16'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
